// File: rtl/pla_pkg.sv
// pla_pkg: shared state encoding and PLA pin-order constants for the phase sequencer
package pla_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DELAY  = 3'd1,
    SAMPLE = 3'd2,
    EVAL   = 3'd3,
    HOLD   = 3'd4
  } state_t;
  localparam logic [7:0] F_IDLE = 8'hFF;
  localparam int I_NCAS    = 0;
  localparam int I_NLORAM  = 1;
  localparam int I_NHIRAM  = 2;
  localparam int I_NCHAREN = 3;
  localparam int I_NVA14   = 4;
  localparam int I_A15     = 5;
  localparam int I_A14     = 6;
  localparam int I_A13     = 7;
  localparam int I_A12     = 8;
  localparam int I_BA      = 9;
  localparam int I_NAEC    = 10;
  localparam int I_RW      = 11;
  localparam int I_NEXROM  = 12;
  localparam int I_NGAME   = 13;
  localparam int I_VA13    = 14;
  localparam int I_VA12    = 15;
  localparam int F_CASRAM  = 0;
  localparam int F_BASIC   = 1;
  localparam int F_KERNAL  = 2;
  localparam int F_CHAROM  = 3;
  localparam int F_GRW     = 4;
  localparam int F_IO      = 5;
  localparam int F_ROML    = 6;
  localparam int F_ROMH    = 7;
endpackage

// File: rtl/pla_phase_sequencer_if.sv
// pla_phase_sequencer_if: phi0, raw/sampled PLA inputs, decoder outputs and status of the sequencer
interface pla_phase_sequencer_if;
  logic        phi0;
  logic [15:0] pla_in;
  logic [7:0]  pla_out;
  logic [15:0] pla_in_q;
  logic [7:0]  f_q;
  logic        half;
  logic        sample_stb;
  logic        locked;
  logic        err_missed;
  modport master (
    output phi0, pla_in, pla_out,
    input  pla_in_q, f_q, half, sample_stb, locked, err_missed
  );
  modport slave (
    input  phi0, pla_in, pla_out,
    output pla_in_q, f_q, half, sample_stb, locked, err_missed
  );
endinterface

// File: rtl/pla_sync_edge.sv
// pla_sync_edge: multi-flop synchronizer with a change detector on the synchronized level
module pla_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic n_reset,
  input  logic din,
  output logic level,
  output logic edge_pulse
);
  logic [STAGES-1:0] sr;
  logic prev;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= {sr[STAGES-2:0], din};
      prev <= sr[STAGES-1];
    end
  assign level = sr[STAGES-1];
  assign edge_pulse = level ^ prev;
endmodule

// File: rtl/pla_phase_sequencer.sv
// pla_phase_sequencer: tracks phi0 halves, samples PLA inputs after each edge and registers decoder outputs
module pla_phase_sequencer import pla_pkg::*; #(
  parameter int SAMPLE_DLY  = 6,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic n_reset,
  pla_phase_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(SAMPLE_DLY + 1);
  state_t state, state_n;
  logic level, edg, timeout, busy;
  logic [DW-1:0] dly_cnt;
  logic [TW-1:0] to_cnt;
  pla_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk, .n_reset, .din(bus.phi0), .level, .edge_pulse(edg)
  );
  assign timeout = !edg && to_cnt == TW'(TIMEOUT - 1);
  assign busy = state == DELAY || state == SAMPLE || state == EVAL;
  assign bus.sample_stb = state == SAMPLE;
  always_comb begin
    state_n = edg ? DELAY : timeout ? IDLE :
      (state == DELAY && dly_cnt == DW'(SAMPLE_DLY - 1)) ? SAMPLE :
      state == SAMPLE ? EVAL : state == EVAL ? HOLD : state;
  end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) state <= IDLE;
    else state <= state_n;
  // A sample already in flight still loads on a coinciding edge; only its EVAL is dropped.
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      dly_cnt        <= '0;
      to_cnt         <= '0;
      bus.half       <= 1'b0;
      bus.err_missed <= 1'b0;
      bus.pla_in_q   <= '0;
      bus.f_q        <= F_IDLE;
      bus.locked     <= 1'b0;
    end else begin
      dly_cnt <= edg ? '0 : state == DELAY ? dly_cnt + DW'(1) : dly_cnt;
      to_cnt  <= edg ? '0 : to_cnt == TW'(TIMEOUT) ? to_cnt : to_cnt + TW'(1);
      if (edg) bus.half <= level;
      if (edg && busy) bus.err_missed <= 1'b1;
      if (state == SAMPLE) bus.pla_in_q <= bus.pla_in;
      if (state == EVAL && !edg) begin
        bus.f_q    <= bus.pla_out;
        bus.locked <= 1'b1;
      end else if (timeout) begin
        bus.f_q    <= F_IDLE;
        bus.locked <= 1'b0;
      end
    end
endmodule

// File: doc/pla_phase_sequencer.md
Name: pla_phase_sequencer

Overview:
- Clocked front-end that sequences the C64 PLA replacement decoder inside the FPGA from a fast oversampling clock.
- Tracks phi0 half-cycles (VIC half / CPU half) and samples the 16 raw PLA inputs at a fixed delay after each phi0 edge.
- Hands the sampled inputs to the combinational decoder, then registers the 8 decoder outputs so the chip-select pins never glitch mid-half-cycle.
- Detects loss of phi0 and forces all selects inactive.

Parameters:
- SAMPLE_DLY, 6: clk cycles from the synchronized phi0 edge to the input sample. Must be >= 1.
- TIMEOUT, 64: clk cycles without a phi0 edge before unlock. Must be > 2*(SAMPLE_DLY+2).
- SYNC_STAGES, 2: flip-flop depth of the phi0 synchronizer. Must be >= 2.

Ports:
- clk  in  1  oversampling clock (nominal 32 MHz, phi0 ~1 MHz)
- n_reset  in  1  asynchronous, active-low reset
- phi0  in  1  asynchronous system phi0
- pla_in  in  16  raw PLA inputs i0..i15 (n_cas ... va12), asynchronous
- pla_out  in  8  combinational decoder outputs f0..f7, driven from pla_in_q
- pla_in_q  out  16  sampled inputs feeding the decoder
- f_q  out  8  registered active-low selects to pins (n_casram..n_romh)
- half  out  1  0 = phi0-low (VIC) half, 1 = phi0-high (CPU) half
- sample_stb  out  1  one-cycle pulse in the cycle pla_in_q is loaded
- locked  out  1  phi0 tracking valid
- err_missed  out  1  sticky: phi0 edge arrived before evaluation completed

Behaviour:
- Reset (async, n_reset=0):
  - f_q=8'hFF, pla_in_q=16'h0000, half=0, sample_stb=0, locked=0, err_missed=0.
  - Synchronizer flops = 0; state=IDLE; counters=0.
- phi0 synchronization and edge detection:
  - phi0 passes through SYNC_STAGES flops; an edge is any change of the last stage versus its previous value.
  - Edge-to-detection latency is SYNC_STAGES+1 clk.
- States: IDLE, DELAY, SAMPLE, EVAL, HOLD.
- On a detected edge, in any state: half <= new synchronized level; dly_cnt <= 0; to_cnt <= 0; next state = DELAY.
- DELAY: dly_cnt increments each clk. When dly_cnt == SAMPLE_DLY-1, go to SAMPLE.
- SAMPLE (1 clk): pla_in_q <= pla_in; sample_stb=1; go to EVAL.
- EVAL (1 clk):
  - The decoder settles on pla_in_q.
  - At the end of EVAL: f_q <= pla_out; locked <= 1; go to HOLD.
- HOLD: f_q held stable until the next edge.
- Sample-to-output latency is 2 clk; edge-to-f_q update is SYNC_STAGES+1+SAMPLE_DLY+2 clk.
- Edge while in DELAY, SAMPLE or EVAL:
  - err_missed <= 1 (sticky until reset).
  - Restart DELAY with the new half; f_q keeps its previous value; the sample in progress is discarded.
  - If SAMPLE and the edge coincide, pla_in_q still loads, but no EVAL follows.
- Timeout:
  - to_cnt increments every clk not carrying an edge, saturating at TIMEOUT.
  - When it reaches TIMEOUT: locked <= 0, f_q <= 8'hFF, state = IDLE. pla_in_q and half are held.
- IDLE: waits for an edge. f_q stays 8'hFF until the first completed EVAL.
- f_q never changes except at the end of EVAL, on timeout, or on reset.
- sample_stb is asserted only in SAMPLE.
- Counter widths: clog2(TIMEOUT+1) for to_cnt, clog2(SAMPLE_DLY+1) for dly_cnt.
- Reset asserted mid-operation forces the reset values immediately. Operation resumes from IDLE after release.

Decomposition:
- Shared package pla_pkg holds:
  - state encoding (IDLE=0, DELAY=1, SAMPLE=2, EVAL=3, HOLD=4);
  - F_IDLE = 8'hFF;
  - bit-index constants for pla_in (I_NCAS=0 .. I_VA12=15) and f_q (F_CASRAM=0 .. F_ROMH=7), matching the decoder pin order.
- One sub-module, pla_sync_edge: parameterized synchronizer plus edge detector, outputting the synchronized level and an edge pulse.
- The decoder itself stays a separate instance at the top level and is not part of this block.

Test Plan:
- Reset: hold n_reset=0 for 5 clk, then release with phi0 static -> f_q=8'hFF, locked=0, sample_stb=0 throughout; after 64 clk still locked=0.
- Nominal: phi0 toggling every 16 clk, pla_in=16'hA5C3, decoder stub pla_out=~pla_in_q[7:0] -> sample_stb exactly SYNC_STAGES+1+6 clk after each phi0 change; f_q=8'h3C two clk later; half follows phi0; locked=1 after the first EVAL.
- Hold stability: change pla_in to 16'h0000 during HOLD -> f_q unchanged until the next sample point, then becomes 8'hFF.
- Early edge: phi0 pulse 4 clk wide -> err_missed=1 sticky; f_q keeps its prior value; the following normal half-cycle updates f_q correctly.
- Timeout: stop phi0 after lock -> exactly 64 clk after the last detected edge, locked=0 and f_q=8'hFF; the next phi0 edge relocks after a full DELAY/SAMPLE/EVAL.
- Async reset mid-DELAY: assert n_reset between clk edges -> all outputs take reset values immediately, without waiting for a clk edge; err_missed clears.
